// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared defaults for param_regfile: geometry, the fixed addresses of the
//   memory-mapped I/O registers and the PC-save group, and a helper that
//   sizes the PC-save group from the PC and register widths.
package regfile_pkg;

   localparam int DEF_DATA_W   = 16;
   localparam int DEF_ADDR_W   = 4;
   localparam int DEF_NUM_RD   = 2;
   localparam int DEF_PC_W     = 32;

   localparam int REG_IN_ADDR  = 8;
   localparam int REG_OUT_ADDR = 7;
   localparam int REG_PC_BASE  = 9;

   // Number of DATA_W-wide registers needed to hold one saved PC.
   function automatic int calc_npc(input int pc_w, input int data_w);
      return pc_w / data_w;
   endfunction

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port
//   One registered read port: selects a register from the flattened
//   register image and captures it on the rising edge.
//   Build option REGFILE_BYPASS_EN: when defined, a register being written
//   at the same edge returns its new value (write-first); otherwise the
//   current contents are returned (read-first).
// Ports
//   clk      clock
//   rst      synchronous active-low reset, clears rd_data
//   rd_addr  register address for this port
//   rd_cur   flattened current register image (inport already spliced in)
//   rd_nxt   flattened next-value image        (REGFILE_BYPASS_EN only)
//   rd_wen   per-register accepted-update flags (REGFILE_BYPASS_EN only)
//   rd_data  registered read data
module regfile_read_port #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [ADDR_W-1:0]               rd_addr,
   input  logic [(2**ADDR_W)*DATA_W-1:0]   rd_cur,
`ifdef REGFILE_BYPASS_EN
   input  logic [(2**ADDR_W)*DATA_W-1:0]   rd_nxt,
   input  logic [(2**ADDR_W)-1:0]          rd_wen,
`endif
   output logic [DATA_W-1:0]               rd_data
);

   logic [DATA_W-1:0] sel;

   always_comb begin
      sel = rd_cur[rd_addr*DATA_W +: DATA_W];
`ifdef REGFILE_BYPASS_EN
      if (rd_wen[rd_addr]) begin
         sel = rd_nxt[rd_addr*DATA_W +: DATA_W];
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_data <= '0;
      end else begin
         rd_data <= sel;
      end
   end

endmodule

// File: rtl/param_regfile.sv
// param_regfile
//   Decode-stage register file with configurable width, depth and number of
//   registered read ports. One register mirrors inport, one drives outport,
//   and a group of NPC registers holds the PC saved on interrupt/call entry.
//   Update priority per register: reset > PC save > inport capture >
//   architectural write.
//   Build option REGFILE_BYPASS_EN: write-first reads (see regfile_read_port).
// Ports
//   clk               clock
//   rst               synchronous active-low reset
//   write_enable      architectural write strobe
//   write_addr        write address
//   write_data        write data
//   read_addr         packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   read_data         packed registered read data, port k at [k*DATA_W +: DATA_W]
//   inport            external input, captured into IN_ADDR every cycle
//   outport           contents of register OUT_ADDR
//   privateRegWrite   PC-save strobe (level sampled)
//   PC                PC value to save, low half into PC_BASE
//   privateRegResult  concatenated PC-save registers
module param_regfile
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int PC_W     = DEF_PC_W,
   parameter int IN_ADDR  = REG_IN_ADDR,
   parameter int OUT_ADDR = REG_OUT_ADDR,
   parameter int PC_BASE  = REG_PC_BASE
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     write_enable,
   input  logic [ADDR_W-1:0]        write_addr,
   input  logic [DATA_W-1:0]        write_data,
   input  logic [NUM_RD*ADDR_W-1:0] read_addr,
   output logic [NUM_RD*DATA_W-1:0] read_data,
   input  logic [DATA_W-1:0]        inport,
   output logic [DATA_W-1:0]        outport,
   input  logic                     privateRegWrite,
   input  logic [PC_W-1:0]          PC,
   output logic [PC_W-1:0]          privateRegResult
);

   localparam int DEPTH  = 2**ADDR_W;
   localparam int NPC    = calc_npc(PC_W, DATA_W);
   localparam int PC_TOP = PC_BASE + NPC - 1;

   if (PC_W % DATA_W != 0) begin : g_chk_pc_w
      $error("param_regfile: PC_W must be a multiple of DATA_W");
   end
   if (PC_TOP >= DEPTH || IN_ADDR >= DEPTH || OUT_ADDR >= DEPTH) begin : g_chk_range
      $error("param_regfile: special register address out of range");
   end
   if (IN_ADDR == OUT_ADDR ||
       (IN_ADDR  >= PC_BASE && IN_ADDR  <= PC_TOP) ||
       (OUT_ADDR >= PC_BASE && OUT_ADDR <= PC_TOP)) begin : g_chk_overlap
      $error("param_regfile: inport, outport and PC-save registers overlap");
   end

   // Flattened register image seen by the read ports; the inport slot carries
   // the live inport so reads of IN_ADDR return the value present at the edge.
   logic [DEPTH*DATA_W-1:0] rd_cur;
`ifdef REGFILE_BYPASS_EN
   logic [DEPTH*DATA_W-1:0] rd_nxt;
   logic [DEPTH-1:0]        rd_wen;
`endif

   for (genvar g = 0; g < DEPTH; g++) begin : g_reg
      localparam bit IS_IN  = (g == IN_ADDR);
      localparam bit IS_OUT = (g == OUT_ADDR);
      localparam bit IS_PC  = (g >= PC_BASE) && (g <= PC_TOP);
      localparam int PC_IDX = IS_PC ? (g - PC_BASE) : 0;

      logic [DATA_W-1:0] q;
      logic [DATA_W-1:0] nxt;
      logic              wen;

      always_comb begin
         nxt = '0;
         wen = 1'b0;
         if (IS_PC && privateRegWrite) begin
            nxt = PC[PC_IDX*DATA_W +: DATA_W];
            wen = 1'b1;
         end else if (IS_IN) begin
            nxt = inport;
            wen = 1'b1;
         end else if (write_enable && (write_addr == ADDR_W'(g))) begin
            nxt = write_data;
            wen = 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (!rst) begin
            q <= '0;
         end else if (wen) begin
            q <= nxt;
         end
      end

      assign rd_cur[g*DATA_W +: DATA_W] = IS_IN ? inport : q;
`ifdef REGFILE_BYPASS_EN
      assign rd_nxt[g*DATA_W +: DATA_W] = nxt;
      assign rd_wen[g]                  = wen;
`endif

      if (IS_OUT) begin : g_out
         assign outport = q;
      end
      if (IS_PC) begin : g_pc
         assign privateRegResult[PC_IDX*DATA_W +: DATA_W] = q;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      regfile_read_port #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_rd (
         .clk     (clk),
         .rst     (rst),
         .rd_addr (read_addr[k*ADDR_W +: ADDR_W]),
         .rd_cur  (rd_cur),
`ifdef REGFILE_BYPASS_EN
         .rd_nxt  (rd_nxt),
         .rd_wen  (rd_wen),
`endif
         .rd_data (read_data[k*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_param_regfile.sv
// tb_param_regfile
//   Directed bench for param_regfile: default geometry instance plus a
//   32-bit / 32-entry / 3-port instance. Inputs change and outputs are
//   sampled on the falling edge.
module tb_param_regfile;

   logic        clk = 1'b0;
   logic        rst;

   // default instance
   logic        write_enable;
   logic [3:0]  write_addr;
   logic [15:0] write_data;
   logic [7:0]  read_addr;
   logic [31:0] read_data;
   logic [15:0] inport;
   logic [15:0] outport;
   logic        privateRegWrite;
   logic [31:0] PC;
   logic [31:0] privateRegResult;

   // wide instance
   logic        w2_write_enable;
   logic [4:0]  w2_write_addr;
   logic [31:0] w2_write_data;
   logic [14:0] w2_read_addr;
   logic [95:0] w2_read_data;
   logic [31:0] w2_inport;
   logic [31:0] w2_outport;
   logic        w2_privateRegWrite;
   logic [31:0] w2_PC;
   logic [31:0] w2_privateRegResult;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   param_regfile dut (
      .clk              (clk),
      .rst              (rst),
      .write_enable     (write_enable),
      .write_addr       (write_addr),
      .write_data       (write_data),
      .read_addr        (read_addr),
      .read_data        (read_data),
      .inport           (inport),
      .outport          (outport),
      .privateRegWrite  (privateRegWrite),
      .PC               (PC),
      .privateRegResult (privateRegResult)
   );

   param_regfile #(
      .DATA_W (32),
      .ADDR_W (5),
      .NUM_RD (3),
      .PC_W   (32)
   ) dut_wide (
      .clk              (clk),
      .rst              (rst),
      .write_enable     (w2_write_enable),
      .write_addr       (w2_write_addr),
      .write_data       (w2_write_data),
      .read_addr        (w2_read_addr),
      .read_data        (w2_read_data),
      .inport           (w2_inport),
      .outport          (w2_outport),
      .privateRegWrite  (w2_privateRegWrite),
      .PC               (w2_PC),
      .privateRegResult (w2_privateRegResult)
   );

   // advance one rising edge, returning on the following falling edge
   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle();
      write_enable       = 1'b0;
      privateRegWrite    = 1'b0;
      w2_write_enable    = 1'b0;
      w2_privateRegWrite = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      write_enable = 1'b1;
      write_addr   = a;
      write_data   = d;
   endtask

   task automatic test_reset();
      // state straight out of the power-on reset
      total++;
      if (read_data !== 32'h0) begin
         bad++; $display("FAIL reset_rd_init: got %h want %h", read_data, 32'h0);
      end
      total++;
      if (outport !== 16'h0) begin
         bad++; $display("FAIL reset_out_init: got %h want %h", outport, 16'h0);
      end
      // dirty the state, then reset again
      wr(4'd3, 16'hBEEF); step();
      wr(4'd7, 16'h1234); step();
      write_enable = 1'b0;
      PC = 32'h1234_5678; privateRegWrite = 1'b1; step();
      privateRegWrite = 1'b0;
      read_addr = {4'd3, 4'd3};
      rst = 1'b0; wr(4'd3, 16'h7777); step();
      rst = 1'b1; idle(); step();
      total++;
      if (read_data[15:0] !== 16'h0000) begin
         bad++; $display("FAIL reset_r3: got %h want %h", read_data[15:0], 16'h0000);
      end
      total++;
      if (outport !== 16'h0) begin
         bad++; $display("FAIL reset_outport: got %h want %h", outport, 16'h0);
      end
      total++;
      if (privateRegResult !== 32'h0) begin
         bad++; $display("FAIL reset_pcsave: got %h want %h", privateRegResult, 32'h0);
      end
   endtask

   task automatic test_rw();
      wr(4'd2, 16'h1234); step();
      idle(); read_addr = {4'd2, 4'd2}; step();
      total++;
      if (read_data[15:0] !== 16'h1234) begin
         bad++; $display("FAIL rw_p0: got %h want %h", read_data[15:0], 16'h1234);
      end
      total++;
      if (read_data[31:16] !== 16'h1234) begin
         bad++; $display("FAIL rw_p1: got %h want %h", read_data[31:16], 16'h1234);
      end
      wr(4'd4, 16'h0444); step();
      wr(4'd6, 16'h0666); step();
      idle(); read_addr = {4'd6, 4'd4}; step();
      total++;
      if (read_data !== 32'h0666_0444) begin
         bad++; $display("FAIL rw_distinct: got %h want %h", read_data, 32'h0666_0444);
      end
   endtask

   task automatic test_bypass();
      logic [15:0] exp_same;
      wr(4'd5, 16'h1111); step();
      wr(4'd5, 16'hA5A5); read_addr = {4'd0, 4'd5}; step();
`ifdef REGFILE_BYPASS_EN
      exp_same = 16'hA5A5;
`else
      exp_same = 16'h1111;
`endif
      total++;
      if (read_data[15:0] !== exp_same) begin
         bad++; $display("FAIL bypass_same_edge: got %h want %h", read_data[15:0], exp_same);
      end
      idle(); step();
      total++;
      if (read_data[15:0] !== 16'hA5A5) begin
         bad++; $display("FAIL bypass_next: got %h want %h", read_data[15:0], 16'hA5A5);
      end
   endtask

   task automatic test_pc_save();
      PC = 32'h0001_8004; privateRegWrite = 1'b1;
      wr(4'd9, 16'hFFFF); step();
      idle();
      total++;
      if (privateRegResult !== 32'h0001_8004) begin
         bad++; $display("FAIL pc_result: got %h want %h", privateRegResult, 32'h0001_8004);
      end
      read_addr = {4'd10, 4'd9}; step();
      total++;
      if (read_data[15:0] !== 16'h8004) begin
         bad++; $display("FAIL pc_r9: got %h want %h", read_data[15:0], 16'h8004);
      end
      total++;
      if (read_data[31:16] !== 16'h0001) begin
         bad++; $display("FAIL pc_r10: got %h want %h", read_data[31:16], 16'h0001);
      end
      // a save does not block a write elsewhere in the same cycle
      PC = 32'hDEAD_BEEF; privateRegWrite = 1'b1;
      wr(4'd3, 16'h3333); step();
      idle(); read_addr = {4'd9, 4'd3}; step();
      total++;
      if (privateRegResult !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL pc_result2: got %h want %h", privateRegResult, 32'hDEAD_BEEF);
      end
      total++;
      if (read_data !== 32'hBEEF_3333) begin
         bad++; $display("FAIL pc_side_write: got %h want %h", read_data, 32'hBEEF_3333);
      end
   endtask

   task automatic test_io();
      inport = 16'h00C3;
      wr(4'd8, 16'h1111); read_addr = {4'd0, 4'd8}; step();
      total++;
      if (read_data[15:0] !== 16'h00C3) begin
         bad++; $display("FAIL io_inport: got %h want %h", read_data[15:0], 16'h00C3);
      end
      idle(); inport = 16'h0077; step();
      total++;
      if (read_data[15:0] !== 16'h0077) begin
         bad++; $display("FAIL io_inport_live: got %h want %h", read_data[15:0], 16'h0077);
      end
      wr(4'd7, 16'h5A5A);
      total++;
      if (outport !== 16'h0000) begin
         bad++; $display("FAIL io_outport_before: got %h want %h", outport, 16'h0000);
      end
      step();
      idle();
      total++;
      if (outport !== 16'h5A5A) begin
         bad++; $display("FAIL io_outport: got %h want %h", outport, 16'h5A5A);
      end
   endtask

   task automatic test_param_sweep();
      w2_write_enable = 1'b1;
      w2_write_addr = 5'd1;  w2_write_data = 32'h1111_1111; step();
      w2_write_addr = 5'd20; w2_write_data = 32'h2020_2020; step();
      w2_write_addr = 5'd31; w2_write_data = 32'h3131_3131; step();
      w2_write_enable = 1'b0;
      w2_PC = 32'hCAFE_F00D; w2_privateRegWrite = 1'b1; step();
      w2_privateRegWrite = 1'b0;
      total++;
      if (w2_privateRegResult !== 32'hCAFE_F00D) begin
         bad++; $display("FAIL sweep_pcresult: got %h want %h", w2_privateRegResult, 32'hCAFE_F00D);
      end
      w2_read_addr = {5'd31, 5'd20, 5'd1}; step();
      total++;
      if (w2_read_data !== {32'h3131_3131, 32'h2020_2020, 32'h1111_1111}) begin
         bad++; $display("FAIL sweep_3ports: got %h want %h", w2_read_data,
                         {32'h3131_3131, 32'h2020_2020, 32'h1111_1111});
      end
      w2_read_addr = {5'd10, 5'd9, 5'd9}; step();
      total++;
      if (w2_read_data[31:0] !== 32'hCAFE_F00D) begin
         bad++; $display("FAIL sweep_r9: got %h want %h", w2_read_data[31:0], 32'hCAFE_F00D);
      end
      total++;
      if (w2_read_data[95:64] !== 32'h0) begin
         bad++; $display("FAIL sweep_r10: got %h want %h", w2_read_data[95:64], 32'h0);
      end
   endtask

   initial begin
      rst = 1'b0;
      write_enable = 1'b0; write_addr = '0; write_data = '0;
      read_addr = '0; inport = '0; privateRegWrite = 1'b0; PC = '0;
      w2_write_enable = 1'b0; w2_write_addr = '0; w2_write_data = '0;
      w2_read_addr = '0; w2_inport = '0; w2_privateRegWrite = 1'b0; w2_PC = '0;
      step(); step();
      rst = 1'b1;

      test_reset();
      test_rw();
      test_bypass();
      test_pc_save();
      test_io();
      test_param_sweep();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/param_regfile.md
Name: param_regfile

Overview:
- Parametrised successor to the 16x16 decode-stage register file: configurable width, depth and read-port count, with registered reads.
- Keeps the memory-mapped I/O registers (inport, outport) and the private PC-save register group used on interrupt/call entry.
- Adds explicit write/save priority and a compile-time write-to-read bypass.
- Sits in the decode stage; read data feeds the ID/EX pipeline register.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 4, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports.
- PC_W, 32, PC width; must be a multiple of DATA_W; PC_W/DATA_W = NPC halves.
- IN_ADDR, 8, register mirroring inport.
- OUT_ADDR, 7, register driven onto outport.
- PC_BASE, 9, first of NPC consecutive PC-save registers, low half first.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- write_enable  in  1  architectural write strobe.
- write_addr  in  ADDR_W  write address.
- write_data  in  DATA_W  write data.
- read_addr  in  NUM_RD*ADDR_W  packed read addresses; port k at [k*ADDR_W +: ADDR_W].
- read_data  out  NUM_RD*DATA_W  packed registered read data, same packing.
- inport  in  DATA_W  external input port.
- outport  out  DATA_W  external output port.
- privateRegWrite  in  1  PC-save strobe.
- PC  in  PC_W  PC value to save.
- privateRegResult  out  PC_W  concatenated PC-save registers, highest half MSB.

Behaviour:
- Reset: rst low at a rising edge clears all registers, read_data, outport and privateRegResult to 0. write_enable, privateRegWrite and inport capture are ignored in that cycle.
- Storage: 2**ADDR_W registers of DATA_W. No hardwired-zero register.
- Read: at each edge, read_data port k <= value selected by read_addr port k. Latency is one cycle. Ports are independent; equal addresses on several ports are legal.
- Inport: at each edge, register IN_ADDR <= inport. Architectural writes to IN_ADDR are dropped. A read of IN_ADDR returns the inport value present at that edge.
- Outport: outport is registered and equals register OUT_ADDR contents after each edge. A write to OUT_ADDR shows on outport one cycle later.
- PC save: privateRegWrite high at an edge writes register PC_BASE+i <= PC[i*DATA_W +: DATA_W] for all i in the same cycle. It is level-sampled; holding it high re-saves every cycle.
- privateRegResult is combinational from the PC-save registers.
- Priority on the same edge: reset > PC save > inport capture > architectural write.
  - A write_enable targeting a PC-save address while privateRegWrite is high is dropped.
  - Writes to other addresses in the same cycle complete normally.
- Address bounds: write_addr and read_addr are always in range (full decode). PC_BASE+NPC-1 must be < 2**ADDR_W, and the ranges IN_ADDR, OUT_ADDR and PC_BASE..PC_BASE+NPC-1 must not overlap. Check both with an elaboration-time assertion.
- No X propagation: unwritten registers read 0 after reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-first. A read at the same edge as an accepted write to the same address returns the new data. This includes PC-save data, but not dropped writes.
- Undefined: read-first. Old contents are returned and the new value is visible from the next read.
- Inport reads return the live inport in both modes.

Decomposition:
- Package regfile_pkg: default DATA_W/ADDR_W/PC_W, the address constants IN_ADDR, OUT_ADDR and PC_BASE, and a function computing NPC.
- One natural sub-module, regfile_read_port: per-port address mux plus bypass compare and output register, instantiated NUM_RD times via generate.

Test Plan:
- Reset: write 0xBEEF to r3, then hold rst low one edge -> read of r3 next cycle = 0x0000; outport = 0; privateRegResult = 0.
- Write/read latency: write 0x1234 to r2 at edge N, read r2 issued at N+1 -> read_data = 0x1234 at N+2. Read on two ports of r2 simultaneously -> both 0x1234.
- Bypass: write 0xA5A5 to r5 and read r5 at the same edge -> 0xA5A5 with REGFILE_BYPASS_EN, previous value without it.
- PC save: PC=0x0001_8004 with privateRegWrite, plus a simultaneous write 0xFFFF to r9 -> r9=0x8004, r10=0x0001, privateRegResult=0x00018004; write dropped.
- I/O: inport=0x00C3 and a write of 0x1111 to r8 -> read r8 = 0x00C3. Write 0x5A5A to r7 -> outport = 0x5A5A one cycle later.
- Param sweep: DATA_W=32, ADDR_W=5, NUM_RD=3, PC_W=32 -> PC saved into a single register PC_BASE; all three ports read distinct registers correctly.
